// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity mode constants
// and a 3-input majority helper used for mid-bit voting.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk   - destination clock
//   reset - synchronous active-high reset, loads RESET_VAL into both flops
//   d     - asynchronous input
//   q     - synchronized output (two clk cycles of latency)
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB-first, optional odd/even parity, one stop bit.
// Each bit is decided by a 3-sample majority vote around mid-bit. The stop bit
// is decided at mid-bit and the FSM returns early so back-to-back frames work.
// Ports:
//   clk        - system clock
//   reset      - synchronous active-high reset
//   rx         - asynchronous serial line, idle high
//   rx_data    - last received byte, held until the next rx_ready
//   rx_ready   - one-cycle strobe; rx_data and the error flags are valid from here
//   rx_active  - high while a frame is in progress (state != IDLE)
//   frame_err  - stop bit decided 0; updated with rx_ready, held
//   parity_err - parity mismatch (always 0 with no parity); updated with rx_ready
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned PARITY       = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       rx_active,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int unsigned CW  = $clog2(CLKS_PER_BIT);
    localparam int unsigned MID = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] CNT_S0   = CW'(MID - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(MID);
    localparam logic [CW-1:0] CNT_DEC  = CW'(MID + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    logic rx_s;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (rx),
        .q    (rx_s)
    );

    rx_state_t     state_q,      state_d;
    logic [CW-1:0] cnt_q,        cnt_d;
    logic [2:0]    bit_idx_q,    bit_idx_d;
    logic [1:0]    samp_q,       samp_d;
    logic [7:0]    shift_q,      shift_d;
    logic          par_bad_q,    par_bad_d;
    logic [7:0]    rx_data_q,    rx_data_d;
    logic          rx_ready_q,   rx_ready_d;
    logic          frame_err_q,  frame_err_d;
    logic          parity_err_q, parity_err_d;

    logic bit_val;
    logic decide;
    logic bit_end;
    logic par_xor;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            samp_q       <= 2'b11;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            rx_data_q    <= '0;
            rx_ready_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            samp_q       <= samp_d;
            shift_q      <= shift_d;
            par_bad_q    <= par_bad_d;
            rx_data_q    <= rx_data_d;
            rx_ready_q   <= rx_ready_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    // Third vote is the live synchronized sample at the decision count.
    assign bit_val = maj3(samp_q[0], samp_q[1], rx_s);
    assign decide  = (cnt_q == CNT_DEC);
    assign bit_end = (cnt_q == CNT_LAST);
    assign par_xor = (^shift_q) ^ bit_val;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        bit_idx_d    = bit_idx_q;
        samp_d       = samp_q;
        shift_d      = shift_q;
        par_bad_d    = par_bad_q;
        rx_data_d    = rx_data_q;
        rx_ready_d   = 1'b0;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;

        if (cnt_q == CNT_S0) samp_d[0] = rx_s;
        if (cnt_q == CNT_S1) samp_d[1] = rx_s;

        // The PARITY parameter shadows the imported enumerator, hence the
        // package-qualified name for that state.
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (decide && bit_val) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (bit_end) begin
                    state_d   = DATA;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (decide) shift_d = {bit_val, shift_q[7:1]};
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            uart_pkg::PARITY: begin
                if (decide) par_bad_d = (PARITY == PAR_ODD) ? ~par_xor : par_xor;
                if (bit_end) begin
                    state_d = STOP;
                    cnt_d   = '0;
                end
            end
            STOP: begin
                if (decide) begin
                    rx_data_d    = shift_q;
                    frame_err_d  = ~bit_val;
                    parity_err_d = (PARITY != PAR_NONE) && par_bad_q;
                    rx_ready_d   = 1'b1;
                    cnt_d        = '0;
                    state_d      = bit_val ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign rx_data    = rx_data_q;
    assign rx_ready   = rx_ready_q;
    assign rx_active  = (state_q != IDLE);
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;

endmodule
